// File: rtl/key_edit_pkg.sv
// -----------------------------------------------------------------------------
// key_edit_pkg
// Shared types, key indices and cursor-search helpers for key_edit_ctrl.
//   state_e          : UI state (VIEW / EDIT)
//   K_EDIT..K_MINUS  : index of each key in the per-key vectors
//   next_unskipped   : next unmasked cursor position in a direction, wrapping
//   first_unskipped  : lowest unmasked cursor position (0 when all masked)
// Masks are passed zero-extended to MAX_POS bits so one helper serves every
// NUM_POS up to MAX_POS.
// -----------------------------------------------------------------------------
package key_edit_pkg;

  typedef enum logic {
    VIEW = 1'b0,
    EDIT = 1'b1
  } state_e;

  localparam int K_EDIT    = 0;
  localparam int K_SWI     = 1;
  localparam int K_PLUS    = 2;
  localparam int K_MINUS   = 3;
  localparam int NUM_KEYS  = 4;

  localparam int MAX_POS   = 32;
  localparam int POS_IDX_W = 5;

  // Searches pos+1, pos+2, ... (dir=0) or pos-1, pos-2, ... (dir=1) modulo
  // num_pos; returns pos itself when no other position is unmasked.
  function automatic int next_unskipped(input logic [MAX_POS-1:0] mask,
                                        input int pos,
                                        input logic dir,
                                        input int num_pos);
    int   res;
    int   cand;
    logic found;
    res   = pos;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i < MAX_POS; i++) begin
      if (dir) begin
        cand = (pos + num_pos - i) % num_pos;
      end else begin
        cand = (pos + i) % num_pos;
      end
      if (!found && (i < num_pos) && !mask[cand[POS_IDX_W-1:0]]) begin
        res   = cand;
        found = 1'b1;
      end else begin
        res   = res;
      end
    end
    return res;
  endfunction

  function automatic int first_unskipped(input logic [MAX_POS-1:0] mask,
                                         input int num_pos);
    int   res;
    logic found;
    res   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_POS; i++) begin
      if (!found && (i < num_pos) && !mask[i[POS_IDX_W-1:0]]) begin
        res   = i;
        found = 1'b1;
      end else begin
        res   = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/key_edit_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// 2-FF synchroniser, counter debounce and registered press pulse for one
// active-low key.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_key_n        : raw key, active-low
//   o_level        : debounced level (1 = released)
//   o_press        : one-cycle pulse on a debounced 1->0 transition
// The debounced level follows the synchronised key once the two have differed
// for DEB_CYCLES consecutive cycles; any cycle of agreement clears the count.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;

  // Synchroniser, stability counter, debounced level and press-edge register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_cnt     <= '0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Press is taken from the registered level history, one cycle after
      // the level itself changes.
      r_press   <= r_level_d & ~r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/key_edit_ctrl.sv
// -----------------------------------------------------------------------------
// key_edit_ctrl
// UI key manager: debounces four active-low keys and maintains the selected
// screen, edit-mode flag and edit cursor, issuing inc/dec requests in EDIT.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_key_*_n           : raw keys (edit, swi, plus, minus), active-low
//   i_swi_reverse       : 0 = cursor moves up, 1 = cursor moves down
//   i_pos_skip_mask     : bit p set = cursor position p is skipped
//   o_screen            : current screen
//   o_edit_mode         : 1 = editing
//   o_edit_pos          : current cursor position
//   o_inc_pulse/o_dec_pulse : one-cycle requests for the digit at o_edit_pos
// Optional build macro KEY_AUTOREPEAT_EN: holding plus/minus in EDIT repeats
// inc/dec after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
// Event priority when presses coincide: edit > swi > plus > minus.
// -----------------------------------------------------------------------------
module key_edit_ctrl
  import key_edit_pkg::*;
#(
  parameter int          NUM_SCREENS      = 3,
  parameter int          NUM_POS          = 8,
  parameter logic [31:0] EDITABLE_SCREENS = 32'h0000_0001,
  parameter int          DEB_CYCLES       = 250000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int          REPEAT_DELAY     = 25_000_000,
  parameter int          REPEAT_PERIOD    = 5_000_000
`endif
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_key_edit_n,
  input  logic                           i_key_swi_n,
  input  logic                           i_key_plus_n,
  input  logic                           i_key_minus_n,
  input  logic                           i_swi_reverse,
  input  logic [NUM_POS-1:0]             i_pos_skip_mask,
  output logic [$clog2(NUM_SCREENS)-1:0] o_screen,
  output logic                           o_edit_mode,
  output logic [$clog2(NUM_POS)-1:0]     o_edit_pos,
  output logic                           o_inc_pulse,
  output logic                           o_dec_pulse
);

  localparam int SCR_W = $clog2(NUM_SCREENS);
  localparam int POS_W = $clog2(NUM_POS);

  logic [NUM_KEYS-1:0] w_keys_n;
  logic [NUM_KEYS-1:0] w_lvl;
  logic [NUM_KEYS-1:0] w_press;

  logic [MAX_POS-1:0]  w_mask_ext;
  logic [POS_W-1:0]    w_first_pos;
  logic [POS_W-1:0]    w_next_swi;
  logic [POS_W-1:0]    w_next_up;
  logic                w_cur_skipped;
  logic                w_screen_editable;
  logic                w_plus_req;
  logic                w_minus_req;
  logic                w_ev_edit;
  logic                w_ev_swi;
  logic                w_ev_plus;
  logic                w_ev_minus;

  state_e              r_state;
  logic [SCR_W-1:0]    r_screen;
  logic                r_edit_mode;
  logic [POS_W-1:0]    r_edit_pos;
  logic                r_inc;
  logic                r_dec;

  assign w_keys_n[K_EDIT]  = i_key_edit_n;
  assign w_keys_n[K_SWI]   = i_key_swi_n;
  assign w_keys_n[K_PLUS]  = i_key_plus_n;
  assign w_keys_n[K_MINUS] = i_key_minus_n;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key_n (w_keys_n[k]),
      .o_level (w_lvl[k]),
      .o_press (w_press[k])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  logic [31:0] r_rep_cnt;
  logic        r_rep_armed;
  logic        r_rep_plus;
  logic        r_rep_minus;
  logic        w_hold_plus;
  logic        w_hold_minus;
  logic [31:0] w_rep_target;

  assign w_hold_plus  = ~w_lvl[K_PLUS];
  assign w_hold_minus = ~w_lvl[K_MINUS] & w_lvl[K_PLUS];
  assign w_rep_target = r_rep_armed ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1);

  // Hold timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rep_cnt   <= 32'd0;
      r_rep_armed <= 1'b0;
      r_rep_plus  <= 1'b0;
      r_rep_minus <= 1'b0;
    end else begin
      r_rep_plus  <= 1'b0;
      r_rep_minus <= 1'b0;
      if ((r_state != EDIT) || !(w_hold_plus || w_hold_minus) ||
          w_press[K_PLUS] || w_press[K_MINUS]) begin
        r_rep_cnt   <= 32'd0;
        r_rep_armed <= 1'b0;
      end else if (r_rep_cnt == w_rep_target) begin
        r_rep_cnt   <= 32'd0;
        r_rep_armed <= 1'b1;
        r_rep_plus  <= w_hold_plus;
        r_rep_minus <= w_hold_minus;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 32'd1;
      end
    end
  end

  // A repeat landing on the cycle EDIT is left must not reach VIEW
  assign w_plus_req  = w_press[K_PLUS]  | (r_rep_plus  & (r_state == EDIT));
  assign w_minus_req = w_press[K_MINUS] | (r_rep_minus & (r_state == EDIT));
`else
  logic w_unused_lvl;
  assign w_unused_lvl = &w_lvl;
  assign w_plus_req   = w_press[K_PLUS];
  assign w_minus_req  = w_press[K_MINUS];
`endif

  // Event arbitration, mask extension and combinational cursor search
  always_comb begin
    w_ev_edit  = w_press[K_EDIT];
    w_ev_swi   = w_press[K_SWI] & ~w_press[K_EDIT];
    w_ev_plus  = w_plus_req & ~w_press[K_EDIT] & ~w_press[K_SWI];
    w_ev_minus = w_minus_req & ~w_press[K_EDIT] & ~w_press[K_SWI] & ~w_plus_req;

    w_mask_ext = '0;
    w_mask_ext[NUM_POS-1:0] = i_pos_skip_mask;

    w_first_pos   = POS_W'(first_unskipped(w_mask_ext, NUM_POS));
    w_next_swi    = POS_W'(next_unskipped(w_mask_ext, int'(r_edit_pos), i_swi_reverse, NUM_POS));
    w_next_up     = POS_W'(next_unskipped(w_mask_ext, int'(r_edit_pos), 1'b0, NUM_POS));
    w_cur_skipped = i_pos_skip_mask[r_edit_pos];

    w_screen_editable = 1'b0;
    for (int s = 0; s < NUM_SCREENS; s++) begin
      if (r_screen == SCR_W'(s)) begin
        w_screen_editable = EDITABLE_SCREENS[s];
      end else begin
        w_screen_editable = w_screen_editable;
      end
    end
  end

  // UI state machine with registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= VIEW;
      r_screen    <= '0;
      r_edit_mode <= 1'b0;
      r_edit_pos  <= '0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      case (r_state)
        VIEW: begin
          if (w_ev_edit) begin
            if (w_screen_editable) begin
              r_state     <= EDIT;
              r_edit_mode <= 1'b1;
              r_edit_pos  <= w_first_pos;
            end else begin
              r_state     <= VIEW;
            end
          end else if (w_ev_plus) begin
            if (r_screen == SCR_W'(NUM_SCREENS - 1)) begin
              r_screen <= '0;
            end else begin
              r_screen <= r_screen + SCR_W'(1);
            end
          end else if (w_ev_minus) begin
            if (r_screen == '0) begin
              r_screen <= SCR_W'(NUM_SCREENS - 1);
            end else begin
              r_screen <= r_screen - SCR_W'(1);
            end
          end else begin
            r_state <= VIEW;
          end
        end
        EDIT: begin
          if (w_ev_edit) begin
            r_state     <= VIEW;
            r_edit_mode <= 1'b0;
            r_edit_pos  <= '0;
          end else begin
            // A swi move already lands on an unskipped position, so it wins
            // over the skip-mask correction.
            if (w_ev_swi) begin
              r_edit_pos <= w_next_swi;
            end else if (w_cur_skipped) begin
              r_edit_pos <= w_next_up;
            end else begin
              r_edit_pos <= r_edit_pos;
            end
            if (w_ev_plus) begin
              r_inc <= 1'b1;
            end else if (w_ev_minus) begin
              r_dec <= 1'b1;
            end else begin
              r_inc <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= VIEW;
          r_edit_mode <= 1'b0;
          r_edit_pos  <= '0;
        end
      endcase
    end
  end

  assign o_screen    = r_screen;
  assign o_edit_mode = r_edit_mode;
  assign o_edit_pos  = r_edit_pos;
  assign o_inc_pulse = r_inc;
  assign o_dec_pulse = r_dec;

endmodule

// File: tb/tb_key_edit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_edit_ctrl
// Directed bench for key_edit_ctrl with DEB_CYCLES=4, 3 screens, 8 positions.
// Expected UI states are queued when a key action is driven and popped and
// compared once the action has had time to reach the outputs.
// -----------------------------------------------------------------------------
module tb_key_edit_ctrl;

  localparam int DEB = 4;
  localparam int NS  = 3;
  localparam int NP  = 8;
  localparam int KE  = 0;
  localparam int KS  = 1;
  localparam int KP  = 2;
  localparam int KM  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    keys_n;
  logic          rev;
  logic [NP-1:0] mask;
  logic [1:0]    screen;
  logic          edit_mode;
  logic [2:0]    edit_pos;
  logic          inc_pulse;
  logic          dec_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int inc_cnt  = 0;
  int dec_cnt  = 0;
  int inc_snap;
  int dec_snap;

  typedef struct {
    string tag;
    int    scr;
    int    mode;
    int    pos;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  key_edit_ctrl #(
    .NUM_SCREENS      (NS),
    .NUM_POS          (NP),
    .EDITABLE_SCREENS (32'h0000_0001),
    .DEB_CYCLES       (DEB)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_key_edit_n    (keys_n[KE]),
    .i_key_swi_n     (keys_n[KS]),
    .i_key_plus_n    (keys_n[KP]),
    .i_key_minus_n   (keys_n[KM]),
    .i_swi_reverse   (rev),
    .i_pos_skip_mask (mask),
    .o_screen        (screen),
    .o_edit_mode     (edit_mode),
    .o_edit_pos      (edit_pos),
    .o_inc_pulse     (inc_pulse),
    .o_dec_pulse     (dec_pulse)
  );

  // Count request pulses on the inactive edge
  always @(negedge clk) begin
    if (inc_pulse === 1'b1) inc_cnt++;
    if (dec_pulse === 1'b1) dec_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input int s, input int m, input int p);
    exp_t e;
    e.tag = tag; e.scr = s; e.mode = m; e.pos = p;
    sbq.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".screen"}, 32'(screen), e.scr);
      chk({e.tag, ".edit_mode"}, 32'(edit_mode), e.mode);
      chk({e.tag, ".edit_pos"}, 32'(edit_pos), e.pos);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: held long enough to act, released, then settled
  task automatic press(input int k);
    keys_n[k] = 1'b0;
    cyc(8);
    keys_n[k] = 1'b1;
    cyc(12);
  endtask

  task automatic press_expect(input int k, input string tag, input int s, input int m, input int p);
    expect_st(tag, s, m, p);
    press(k);
    check_sb();
  endtask

  initial begin
    rst_n  = 1'b0;
    keys_n = 4'hF;
    rev    = 1'b0;
    mask   = 8'h00;
    cyc(2);
    expect_st("reset", 0, 0, 0);
    check_sb();
    chk("reset.inc", 32'(inc_pulse), 32'd0);
    chk("reset.dec", 32'(dec_pulse), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Bounce (3 low, 1 high) then a 4-cycle clean press: acts on cycle 8
    keys_n[KP] = 1'b0; cyc(3);
    keys_n[KP] = 1'b1; cyc(1);
    keys_n[KP] = 1'b0;
    expect_st("deb_early", 0, 0, 0);
    expect_st("deb_exact", 1, 0, 0);
    cyc(7); check_sb();
    cyc(1); check_sb();
    keys_n[KP] = 1'b1;
    cyc(12);

    press_expect(KP, "plus_2", 2, 0, 0);
    press_expect(KP, "plus_wrap", 0, 0, 0);
    press_expect(KP, "plus_1", 1, 0, 0);

    // Edit entry only on editable screen 0
    press_expect(KE, "edit_noneditable", 1, 0, 0);
    press_expect(KM, "minus_0", 0, 0, 0);
    press_expect(KE, "edit_enter", 0, 1, 0);
    inc_snap = inc_cnt; dec_snap = dec_cnt;
    press_expect(KP, "edit_plus", 0, 1, 0);
    chk("edit_plus.inc_count", 32'(inc_cnt - inc_snap), 32'd1);
    chk("edit_plus.dec_count", 32'(dec_cnt - dec_snap), 32'd0);
    inc_snap = inc_cnt; dec_snap = dec_cnt;
    press_expect(KM, "edit_minus", 0, 1, 0);
    chk("edit_minus.inc_count", 32'(inc_cnt - inc_snap), 32'd0);
    chk("edit_minus.dec_count", 32'(dec_cnt - dec_snap), 32'd1);

    // Cursor up to 3, then asynchronous reset between clock edges
    press_expect(KS, "swi_1", 0, 1, 1);
    press_expect(KS, "swi_2", 0, 1, 2);
    press_expect(KS, "swi_3", 0, 1, 3);
    #2;
    rst_n = 1'b0;
    #1;
    expect_st("async_reset", 0, 0, 0);
    check_sb();
    chk("async_reset.inc", 32'(inc_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // Skip mask moves
    press_expect(KE, "reenter", 0, 1, 0);
    for (int i = 1; i <= 4; i++) press_expect(KS, "swi_walk", 0, 1, i);
    mask = 8'b0110_0000;
    press_expect(KS, "skip_5_6", 0, 1, 7);
    press_expect(KS, "skip_wrap_up", 0, 1, 0);
    rev = 1'b1;
    press_expect(KS, "skip_wrap_down", 0, 1, 7);

    // Mask change under the cursor
    rev  = 1'b0;
    mask = 8'h00;
    press_expect(KS, "to_0", 0, 1, 0);
    press_expect(KS, "to_1", 0, 1, 1);
    mask = 8'b0000_0010;
    expect_st("mask_move", 0, 1, 2);
    cyc(1);
    check_sb();
    mask = 8'hFF;
    expect_st("mask_all_stay", 0, 1, 2);
    cyc(2);
    check_sb();
    press_expect(KS, "mask_all_swi", 0, 1, 2);

    // Coincident edit + plus in EDIT: edit wins, plus dropped
    mask = 8'h00;
    inc_snap = inc_cnt;
    expect_st("simul_edit_plus", 0, 0, 0);
    keys_n[KE] = 1'b0; keys_n[KP] = 1'b0;
    cyc(8);
    keys_n[KE] = 1'b1; keys_n[KP] = 1'b1;
    cyc(12);
    check_sb();
    chk("simul.inc_count", 32'(inc_cnt - inc_snap), 32'd0);

    // Screen wrap downward and back
    press_expect(KM, "minus_wrap", 2, 0, 0);
    press_expect(KP, "plus_wrap2", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_edit_ctrl.md
Name: key_edit_ctrl

Overview:
Parametrised successor to the clock-display key manager. Takes four raw active-low push-buttons and produces the UI control state: the selected screen, the edit-mode flag and the edit cursor. Adds what the previous block lacked: on-chip synchronisation and debounce, N screens and M cursor positions, a runtime skip mask in place of the hard-coded 12/24h skips, and inc/dec pulses to the time/date counters. Sits between the board keys and the counter/display blocks.

Parameters:
NUM_SCREENS, 3, number of view screens (>=2)
NUM_POS, 8, number of editable cursor positions (>=2)
EDITABLE_SCREENS, 'b001, bit s set = edit mode may be entered on screen s
DEB_CYCLES, 250000, consecutive stable cycles for a debounced level change (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
key_edit_n  in  1  raw edit-toggle key, active-low
key_swi_n  in  1  raw cursor-move key, active-low
key_plus_n  in  1  raw plus key, active-low
key_minus_n  in  1  raw minus key, active-low
swi_reverse  in  1  0 = cursor moves up, 1 = cursor moves down
pos_skip_mask  in  NUM_POS  bit p set = position p is skipped (e.g. unused hour digit in 12h mode)
screen  out  $clog2(NUM_SCREENS)  current screen
edit_mode  out  1  1 = editing
edit_pos  out  $clog2(NUM_POS)  current cursor position
inc_pulse  out  1  one-cycle increment request for the digit at edit_pos
dec_pulse  out  1  one-cycle decrement request for the digit at edit_pos

Behaviour:
- Reset (async, active-low): screen=0, edit_mode=0, edit_pos=0, inc_pulse=dec_pulse=0, sync FFs and debounced levels=1 (released), debounce counters=0, state=VIEW.
- Per key: 2-FF synchroniser, then debounce. The debounced level takes the synchronised value after that value has differed from it for DEB_CYCLES consecutive cycles. Any bounce clears the counter.
- A registered press pulse is raised for 1 cycle on a 1->0 transition of the debounced level. Releases produce no event.
- Latency: the action is visible on the outputs on the clock after the press pulse. Total from a clean raw edge is 2+DEB_CYCLES+2 cycles.
- Simultaneous pulses in one cycle: only the highest-priority event acts, in the order edit > swi > plus > minus. The others are dropped.
- FSM VIEW:
  - plus: screen = screen+1, wrapping NUM_SCREENS-1 -> 0.
  - minus: screen = screen-1, wrapping 0 -> NUM_SCREENS-1.
  - edit: if EDITABLE_SCREENS[screen], go to EDIT with edit_mode=1 and edit_pos = first unskipped position from 0 upward (0 if all are skipped). Otherwise ignored.
  - swi: ignored.
- FSM EDIT:
  - plus: inc_pulse=1 for 1 cycle.
  - minus: dec_pulse=1 for 1 cycle.
  - swi: edit_pos moves to the next unskipped position in the swi_reverse direction, wrapping modulo NUM_POS. If no other position is unskipped, edit_pos is unchanged.
  - edit: go to VIEW, edit_mode=0, edit_pos=0.
  - screen is frozen in EDIT.
- Skip-mask change in EDIT: if pos_skip_mask[edit_pos] becomes 1, edit_pos moves to the next unskipped position upward (wrapping) on the next cycle. A swi in the same cycle takes precedence and already yields an unskipped position.
- Next-position search is combinational over NUM_POS, with no iterative state.
- Screen-change wrap uses explicit compare, never reliance on width overflow.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined: in EDIT, holding plus/minus debounced-low for REPEAT_DELAY cycles emits an extra inc/dec pulse, then another every REPEAT_PERIOD cycles until release. REPEAT_DELAY (default 25_000_000) and REPEAT_PERIOD (default 5_000_000) become parameters. Repeats follow the same priority rules. Leaving EDIT stops repeating.
- Undefined: exactly one pulse per press, and no repeat counters exist.

Decomposition:
- Package key_edit_pkg:
  - state enum {VIEW, EDIT}
  - key index constants K_EDIT=0, K_SWI=1, K_PLUS=2, K_MINUS=3
  - next-unskipped-position function (mask, pos, dir)
- Sub-module key_debounce (sync + debounce + press pulse, parameter DEB_CYCLES), instantiated once per key.

Test Plan:
(All with DEB_CYCLES=4, NUM_SCREENS=3, NUM_POS=8, mask=0.)
- Reset: assert reset mid-edit with edit_pos=3 -> all outputs 0 immediately, without a clock edge.
- Debounce: key_plus_n low for 3 cycles, high, low for 4 cycles -> no screen change, then screen=1 after 2+4+2 cycles. Three further presses -> 2, 0, 1.
- Edit entry: on screen 1 press edit -> edit_mode stays 0. On screen 0 press edit -> edit_mode=1, edit_pos=0. Press plus -> one inc_pulse, screen unchanged.
- Skip move: mask=8'b0110_0000, edit_pos=4, swi_reverse=0, press swi -> edit_pos=7. Press again -> 0. Set swi_reverse=1 and press -> 7.
- Mask change: edit_pos=1, mask set to 8'b0000_0010 -> edit_pos=2 on the next cycle. Mask=8'hFF -> edit_pos stays, and swi does nothing.
- Simultaneous: edit and plus pulses in the same cycle while in EDIT -> returns to VIEW, no inc_pulse, screen unchanged.
